npu_add_tree_top: RTL and testbench

- 8-lane, 8-bit dot-product / adder-tree block for the NPU cube.
- Multiplies eight packed 8-bit data bytes by eight packed 8-bit signed parameter bytes and sums the eight products.
- Produces one 19-bit two's-complement result per clock.
- Data bytes are interpreted as signed or unsigned according to a mode input; parameter bytes are always signed.

---
 rtl/npu_add_tree_top.sv | 55 +++++
 tb/tb_npu_add_tree_top.sv | 137 +++++++++++++
 2 files changed

// File: rtl/npu_add_tree_top.sv
// Eight-lane 8x8 dot product: data bytes (signed or unsigned by mode) times signed parameter bytes, summed by a 3-level adder tree.
// Latency 1 cycle (single output register), one result per cycle; no handshake, so no backpressure.
module npu_add_tree_top #(
    parameter int LANES = 8,
    parameter int DW    = 8,
    parameter int RW    = 19
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LANES*DW-1:0]   add_tree_data,
    input  logic [LANES*DW-1:0]   add_tree_para,
    input  logic                  is_signed_data,
    output logic [RW-1:0]         add_result
);

    logic [16:0] w_prod [LANES];
    logic [17:0] w_l1   [4];
    logic [18:0] w_l2   [2];
    logic [18:0] w_sum;
    logic [RW-1:0] r_add_result;

    // Data gets a 9th bit that is its sign only in signed mode; products are
    // formed at 17 bits, which holds every 9x8 signed product exactly.
    for (genvar i = 0; i < LANES; i++) begin : g_mul
        logic        w_dsx;
        logic [16:0] w_d;
        logic [16:0] w_p;
        assign w_dsx     = is_signed_data & add_tree_data[DW*i+7];
        assign w_d       = {{8{w_dsx}}, w_dsx, add_tree_data[DW*i +: DW]};
        assign w_p       = {{9{add_tree_para[DW*i+7]}}, add_tree_para[DW*i +: DW]};
        assign w_prod[i] = w_d * w_p;
    end

    for (genvar j = 0; j < 4; j++) begin : g_l1
        assign w_l1[j] = {w_prod[2*j][16], w_prod[2*j]} + {w_prod[2*j+1][16], w_prod[2*j+1]};
    end

    for (genvar j = 0; j < 2; j++) begin : g_l2
        assign w_l2[j] = {w_l1[2*j][17], w_l1[2*j]} + {w_l1[2*j+1][17], w_l1[2*j+1]};
    end

    // Full-precision sum spans -261120..259080, so the 19-bit add cannot wrap.
    assign w_sum = w_l2[0] + w_l2[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_add_result <= '0;
        end else begin
            r_add_result <= w_sum;
        end
    end

    assign add_result = r_add_result;

endmodule

// File: tb/tb_npu_add_tree_top.sv
// Randomized and directed checks of npu_add_tree_top against an integer dot-product model.
module tb_npu_add_tree_top;

    logic        clk;
    logic        rst_n;
    logic [63:0] add_tree_data;
    logic [63:0] add_tree_para;
    logic        is_signed_data;
    logic [18:0] add_result;

    int n_tests;
    int n_fail;

    npu_add_tree_top dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .add_tree_data  (add_tree_data),
        .add_tree_para  (add_tree_para),
        .is_signed_data (is_signed_data),
        .add_result     (add_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%05h) expected %0d (0x%05h)",
                     tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    function automatic logic [18:0] ref_sum(input logic [63:0] d, input logic [63:0] p, input logic m);
        int s;
        int dv;
        int pv;
        logic [7:0] db;
        logic [7:0] pb;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            db = d[8*i +: 8];
            pb = p[8*i +: 8];
            dv = m ? int'($signed(db)) : int'(db);
            pv = int'($signed(pb));
            s += dv * pv;
        end
        return s[18:0];
    endfunction

    // Drive operands just after an edge, then check the registered result one edge later.
    task automatic step(input string tag, input logic [63:0] d, input logic [63:0] p,
                        input logic m, input logic [18:0] exp);
        add_tree_data  = d;
        add_tree_para  = p;
        is_signed_data = m;
        @(posedge clk);
        #1;
        chk(tag, add_result, exp);
    endtask

    initial begin
        logic [63:0] d;
        logic [63:0] p;
        logic        m;
        logic [18:0] prev;
        n_tests = 0;
        n_fail  = 0;

        rst_n          = 1'b0;
        add_tree_data  = {8{8'hFF}};
        add_tree_para  = {8{8'h7F}};
        is_signed_data = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold", add_result, 19'd0);

        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_first_uns", add_result, 19'h3F408);
        step("ff_7f_sgn", {8{8'hFF}}, {8{8'h7F}}, 1'b1, 19'(-1016));

        step("ff_80_uns", {8{8'hFF}}, {8{8'h80}}, 1'b0, 19'h40400);
        step("ff_80_sgn", {8{8'hFF}}, {8{8'h80}}, 1'b1, 19'd1024);
        step("80_80_sgn", {8{8'h80}}, {8{8'h80}}, 1'b1, 19'd131072);
        step("80_7f_sgn", {8{8'h80}}, {8{8'h7F}}, 1'b1, 19'(-130048));

        for (int k = 0; k < 8; k++) begin
            d = 64'h03 << (8*k);
            p = 64'hFE << (8*k);
            step($sformatf("lane%0d_uns", k), d, p, 1'b0, 19'(-6));
            step($sformatf("lane%0d_sgn", k), d, p, 1'b1, 19'(-6));
        end

        // Mode toggles every cycle; the output must hold the previous result until the next edge.
        prev = add_result;
        for (int c = 0; c < 8; c++) begin
            m = (c % 2 == 0);
            add_tree_data  = {8{8'h80}};
            add_tree_para  = {8{8'h01}};
            is_signed_data = m;
            #3;
            chk($sformatf("toggle_hold%0d", c), add_result, prev);
            @(posedge clk);
            #1;
            prev = m ? 19'(-1024) : 19'd1024;
            chk($sformatf("toggle%0d", c), add_result, prev);
        end

        // Asynchronous reset between edges clears the output at once and discards in-flight data.
        add_tree_data  = {8{8'h7F}};
        add_tree_para  = {8{8'h7F}};
        is_signed_data = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", add_result, 19'd0);
        @(posedge clk);
        #1;
        chk("rst_mid_hold", add_result, 19'd0);
        rst_n = 1'b1;
        step("rst_release", {8{8'h7F}}, {8{8'h7F}}, 1'b1, ref_sum({8{8'h7F}}, {8{8'h7F}}, 1'b1));

        for (int n = 0; n < 10000; n++) begin
            d = {$urandom(), $urandom()};
            p = {$urandom(), $urandom()};
            m = 1'($urandom_range(0, 1));
            step("random", d, p, m, ref_sum(d, p, m));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
